// File: rtl/rtan_sweep_ctrl_if.sv
// Result stream of the r*tan sweep: valid/ready handshake carrying angle index and value.
interface rtan_sweep_ctrl_if #(
  parameter int OUT_W = 11
);
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_idx;
  logic [OUT_W-1:0] out_rtan;

  modport master (
    output out_valid,
    output out_idx,
    output out_rtan,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_rtan,
    output out_ready
  );
endinterface

// File: rtl/rtan_sweep_ctrl.sv
// Time-shared r*tan(k*15 deg) sequencer: one multiply per angle, results streamed in index order.
// Build option RTAN_ABS_OUT_EN: emit min(|res|,255) as an 8-bit magnitude instead of signed res.
module rtan_sweep_ctrl #(
  parameter int R_W      = 9,
  parameter int OUT_W    = 11,
  parameter int N_ANG    = 6,
  parameter int TAN_FRAC = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic signed [R_W-1:0] r,
  output logic                  busy,
  output logic                  done,
  rtan_sweep_ctrl_if.master     out_if
);

  localparam int TAN_W  = 10;
  localparam int PROD_W = R_W + TAN_W + 1;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic [2:0]              LAST_IDX = 3'(N_ANG - 1);
  localparam logic signed [SUM_W-1:0] ROUND    = SUM_W'(2**(TAN_FRAC-1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_OUT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [R_W-1:0]    r_q;
  logic [2:0]               idx_q;
  logic [OUT_W-1:0]         res_q;

  logic                     load;
  logic                     mul_en;
  logic                     step;
  logic                     valid;

  logic [TAN_W-1:0]         tan_k;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  rounded;
  logic signed [SUM_W-1:0]  scaled;
  logic [OUT_W-1:0]         res_nxt;

  // tan(k*15 deg) in unsigned Q.8
  always_comb begin
    tan_k = '0;
    case (idx_q)
      3'd0:    tan_k = 10'd0;
      3'd1:    tan_k = 10'd69;
      3'd2:    tan_k = 10'd148;
      3'd3:    tan_k = 10'd256;
      3'd4:    tan_k = 10'd443;
      3'd5:    tan_k = 10'd955;
      default: tan_k = '0;
    endcase
  end

`ifdef RTAN_ABS_OUT_EN
  logic [SUM_W-1:0] mag;

  always_comb begin
    prod    = PROD_W'(r_q) * $signed(PROD_W'(tan_k));
    rounded = SUM_W'(prod) + ROUND;
    scaled  = rounded >>> TAN_FRAC;
    mag     = scaled[SUM_W-1] ? SUM_W'(-scaled) : SUM_W'(scaled);
    res_nxt = (mag > SUM_W'(255)) ? OUT_W'(255) : OUT_W'(mag[7:0]);
  end
`else
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(2**(OUT_W-1) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-(2**(OUT_W-1)));

  always_comb begin
    prod    = PROD_W'(r_q) * $signed(PROD_W'(tan_k));
    rounded = SUM_W'(prod) + ROUND;
    scaled  = rounded >>> TAN_FRAC;
    if (scaled > SAT_HI) begin
      res_nxt = SAT_HI[OUT_W-1:0];
    end else if (scaled < SAT_LO) begin
      res_nxt = SAT_LO[OUT_W-1:0];
    end else begin
      res_nxt = scaled[OUT_W-1:0];
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort outranks the OUT handshake, so a cancelled result is never counted as taken
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    mul_en    = 1'b0;
    step      = 1'b0;
    valid     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          mul_en    = 1'b1;
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        busy  = 1'b1;
        valid = 1'b1;
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (out_if.out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            step      = 1'b1;
            state_nxt = S_MUL;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q   <= '0;
      idx_q <= '0;
      res_q <= '0;
    end else begin
      if (load) begin
        r_q   <= r;
        idx_q <= '0;
      end
      if (mul_en) begin
        res_q <= res_nxt;
      end
      if (step) begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  assign out_if.out_valid = valid;
  assign out_if.out_idx   = idx_q;
  assign out_if.out_rtan  = res_q;

endmodule
